// File: rtl/exp_coef_cmult.sv
`default_nettype none
// ============================================================================
// Module   : exp_coef_cmult
// Purpose  : Complex multiply of FFT samples by the exp(-i2*pi*mpL/Np) LUT
//            coefficient, with Np-sample block framing and saturating output.
// Revision : 1.0 - initial release
// ============================================================================
module exp_coef_cmult #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 10,
    parameter int OUT_W  = 18
) (
    input  logic                     clock,
    input  logic                     i_reset_n,
    input  logic                     i_enable,
    input  logic [2:0]               i_NFFT_sel,
    input  logic [2*DATA_W-1:0]      s_axis_data_tdata,
    input  logic                     s_axis_data_tvalid,
    input  logic                     s_axis_data_tlast,
    input  logic signed [COEF_W-1:0] i_exp_sample_real,
    input  logic signed [COEF_W-1:0] i_exp_sample_imag,
    output logic [2*OUT_W-1:0]       m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic [15:0]              o_block_cnt,
    output logic                     o_tlast_err,
    output logic                     o_sat
);

    localparam int c_PROD_W = DATA_W + COEF_W;
    localparam int c_SUM_W  = c_PROD_W + 1;
    localparam int c_CNT_W  = 10;
    localparam logic signed [c_SUM_W-1:0] c_RND  = c_SUM_W'(128);
    localparam logic signed [c_SUM_W-1:0] c_OMAX = c_SUM_W'((1 <<< (OUT_W-1)) - 1);
    localparam logic signed [c_SUM_W-1:0] c_OMIN = c_SUM_W'(-(1 <<< (OUT_W-1)));

    // Round half-up in Q.8, then clip; MSB of the result is the clip flag.
    function automatic logic [OUT_W:0] f_round_sat(input logic signed [c_SUM_W-1:0] v);
        logic signed [c_SUM_W-1:0] r;
        r = (v + c_RND) >>> 8;
        if (r > c_OMAX)
            f_round_sat = {1'b1, c_OMAX[OUT_W-1:0]};
        else if (r < c_OMIN)
            f_round_sat = {1'b1, c_OMIN[OUT_W-1:0]};
        else
            f_round_sat = {1'b0, r[OUT_W-1:0]};
    endfunction

    // ------------------------------------------------------------------
    // Framing
    // ------------------------------------------------------------------
    logic                 w_accept;
    logic [c_CNT_W-1:0]   w_sel_np_m1;
    logic [c_CNT_W-1:0]   w_np_m1;
    logic                 w_is_last;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   r_np_m1;
    logic                 r_tlast_err;

    assign w_accept = s_axis_data_tvalid & i_enable;

    always_comb begin
        w_sel_np_m1 = 10'd1023;
        case (i_NFFT_sel)
            3'd0:    w_sel_np_m1 = 10'd15;
            3'd1:    w_sel_np_m1 = 10'd31;
            3'd2:    w_sel_np_m1 = 10'd63;
            3'd3:    w_sel_np_m1 = 10'd127;
            3'd4:    w_sel_np_m1 = 10'd255;
            3'd5:    w_sel_np_m1 = 10'd511;
            default: w_sel_np_m1 = 10'd1023;
        endcase
    end

    // The block length is taken live from the select only on the first sample.
    assign w_np_m1   = (r_cnt == '0) ? w_sel_np_m1 : r_np_m1;
    assign w_is_last = (r_cnt == w_np_m1);

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt       <= '0;
            r_np_m1     <= '0;
            r_tlast_err <= 1'b0;
        end else if (w_accept) begin
            if (r_cnt == '0)
                r_np_m1 <= w_sel_np_m1;
            if (w_is_last || s_axis_data_tlast)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (s_axis_data_tlast != w_is_last)
                r_tlast_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath P0..P3
    // ------------------------------------------------------------------
    logic                       r_p0_valid, r_p1_valid, r_p2_valid;
    logic                       r_p0_last,  r_p1_last,  r_p2_last;
    logic signed [DATA_W-1:0]   r_p0_re, r_p0_im;
    logic signed [c_PROD_W-1:0] r_p1_ac, r_p1_bd, r_p1_ad, r_p1_bc;
    logic signed [c_SUM_W-1:0]  r_p2_re, r_p2_im;
    logic [OUT_W:0]             w_out_re, w_out_im;
    logic [2*OUT_W-1:0]         r_tdata;
    logic                       r_tvalid, r_tlast, r_sat;
    logic [15:0]                r_block_cnt;

    assign w_out_re = f_round_sat(r_p2_re);
    assign w_out_im = f_round_sat(r_p2_im);

    always_ff @(posedge clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_p0_valid  <= 1'b0;
            r_p0_last   <= 1'b0;
            r_p0_re     <= '0;
            r_p0_im     <= '0;
            r_p1_valid  <= 1'b0;
            r_p1_last   <= 1'b0;
            r_p1_ac     <= '0;
            r_p1_bd     <= '0;
            r_p1_ad     <= '0;
            r_p1_bc     <= '0;
            r_p2_valid  <= 1'b0;
            r_p2_last   <= 1'b0;
            r_p2_re     <= '0;
            r_p2_im     <= '0;
            r_tdata     <= '0;
            r_tvalid    <= 1'b0;
            r_tlast     <= 1'b0;
            r_sat       <= 1'b0;
            r_block_cnt <= '0;
        end else begin
            r_p0_valid <= w_accept;
            if (w_accept) begin
                r_p0_re   <= s_axis_data_tdata[DATA_W-1:0];
                r_p0_im   <= s_axis_data_tdata[2*DATA_W-1:DATA_W];
                r_p0_last <= w_is_last;
            end

            // The LUT coefficient arrives one cycle behind its data sample.
            r_p1_valid <= r_p0_valid;
            if (r_p0_valid) begin
                r_p1_last <= r_p0_last;
                r_p1_ac   <= c_PROD_W'(r_p0_re) * c_PROD_W'(i_exp_sample_real);
                r_p1_bd   <= c_PROD_W'(r_p0_im) * c_PROD_W'(i_exp_sample_imag);
                r_p1_ad   <= c_PROD_W'(r_p0_re) * c_PROD_W'(i_exp_sample_imag);
                r_p1_bc   <= c_PROD_W'(r_p0_im) * c_PROD_W'(i_exp_sample_real);
            end

            r_p2_valid <= r_p1_valid;
            if (r_p1_valid) begin
                r_p2_last <= r_p1_last;
                r_p2_re   <= c_SUM_W'(r_p1_ac) - c_SUM_W'(r_p1_bd);
                r_p2_im   <= c_SUM_W'(r_p1_ad) + c_SUM_W'(r_p1_bc);
            end

            r_tvalid <= r_p2_valid;
            r_tlast  <= r_p2_valid & r_p2_last;
            if (r_p2_valid) begin
                r_tdata <= {w_out_im[OUT_W-1:0], w_out_re[OUT_W-1:0]};
                if (w_out_re[OUT_W] || w_out_im[OUT_W])
                    r_sat <= 1'b1;
                if (r_p2_last)
                    r_block_cnt <= r_block_cnt + 16'd1;
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign o_block_cnt   = r_block_cnt;
    assign o_tlast_err   = r_tlast_err;
    assign o_sat         = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_exp_coef_cmult.sv
`default_nettype none
// ============================================================================
// Module   : tb_exp_coef_cmult
// Purpose  : Self-checking bench for exp_coef_cmult (vector table, directed
//            framing/reset sequences and randomized traffic vs a model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_exp_coef_cmult;

    localparam int DATA_W = 16;
    localparam int COEF_W = 10;
    localparam int OUT_W  = 18;

    logic                     clock = 1'b0;
    logic                     i_reset_n;
    logic                     i_enable;
    logic [2:0]               i_NFFT_sel;
    logic [2*DATA_W-1:0]      s_axis_data_tdata;
    logic                     s_axis_data_tvalid;
    logic                     s_axis_data_tlast;
    logic signed [COEF_W-1:0] i_exp_sample_real;
    logic signed [COEF_W-1:0] i_exp_sample_imag;
    logic [2*OUT_W-1:0]       m_axis_tdata;
    logic                     m_axis_tvalid;
    logic                     m_axis_tlast;
    logic [15:0]              o_block_cnt;
    logic                     o_tlast_err;
    logic                     o_sat;

    exp_coef_cmult #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
        .clock              (clock),
        .i_reset_n          (i_reset_n),
        .i_enable           (i_enable),
        .i_NFFT_sel         (i_NFFT_sel),
        .s_axis_data_tdata  (s_axis_data_tdata),
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .s_axis_data_tlast  (s_axis_data_tlast),
        .i_exp_sample_real  (i_exp_sample_real),
        .i_exp_sample_imag  (i_exp_sample_imag),
        .m_axis_tdata       (m_axis_tdata),
        .m_axis_tvalid      (m_axis_tvalid),
        .m_axis_tlast       (m_axis_tlast),
        .o_block_cnt        (o_block_cnt),
        .o_tlast_err        (o_tlast_err),
        .o_sat              (o_sat)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2*OUT_W-1:0] data;
        bit                 last;
        int                 edge_n;
    } exp_t;

    typedef struct {
        logic [15:0] a, b;
        logic [9:0]  c, d;
        logic [17:0] re, im;
        bit          sat;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          compared   = 0;
    int          mismatched = 0;
    int          cyc        = 0;
    int          m_cnt, m_np, m_blocks;
    bit          m_err, m_sat;
    bit          pend;
    logic [9:0]  pend_c, pend_d;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact integer complex product, round half-up, clip.
    function automatic logic [2*OUT_W:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                                  input logic [9:0] c, input logic [9:0] d);
        longint sa, sb_, sc, sd, re, im;
        bit     s;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        sc  = longint'($signed(c));
        sd  = longint'($signed(d));
        re  = (sa * sc - sb_ * sd + 128) >>> 8;
        im  = (sa * sd + sb_ * sc + 128) >>> 8;
        s   = 1'b0;
        if (re > 131071) begin re = 131071; s = 1'b1; end
        else if (re < -131072) begin re = -131072; s = 1'b1; end
        if (im > 131071) begin im = 131071; s = 1'b1; end
        else if (im < -131072) begin im = -131072; s = 1'b1; end
        return {s, OUT_W'(im), OUT_W'(re)};
    endfunction

    // Drive one cycle of input; the LUT coefficient of the previous accept rides along.
    task automatic drive(input bit v, input bit en, input logic [15:0] a, input logic [15:0] b,
                         input logic [9:0] c, input logic [9:0] d, input bit tl, input logic [2:0] sel);
        bit                 lst;
        logic [2*OUT_W:0]   r;
        int                 sh;
        s_axis_data_tvalid = v;
        i_enable           = en;
        s_axis_data_tdata  = {b, a};
        s_axis_data_tlast  = tl;
        i_NFFT_sel         = sel;
        if (pend) begin
            i_exp_sample_real = pend_c;
            i_exp_sample_imag = pend_d;
        end else begin
            i_exp_sample_real = 10'($urandom);
            i_exp_sample_imag = 10'($urandom);
        end
        @(posedge clock);
        #1;
        pend = 1'b0;
        if (v && en) begin
            sh = (sel > 3'd6) ? 6 : int'(sel);
            if (m_cnt == 0) m_np = 16 << sh;
            lst = (m_cnt == m_np - 1);
            if (tl != lst) m_err = 1'b1;
            m_cnt = (lst || tl) ? 0 : m_cnt + 1;
            r = ref_mul(a, b, c, d);
            if (r[2*OUT_W]) m_sat = 1'b1;
            sb.push_back('{data: r[2*OUT_W-1:0], last: lst, edge_n: cyc + 3});
            pend   = 1'b1;
            pend_c = c;
            pend_d = d;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 1'b0, 16'($urandom), 16'($urandom), 10'($urandom), 10'($urandom), 1'b0, 3'd0);
    endtask

    task automatic rnd_sample(input bit tl, input logic [2:0] sel);
        drive(1'b1, 1'b1, 16'($urandom), 16'($urandom), 10'($urandom), 10'($urandom), tl, sel);
    endtask

    task automatic do_reset();
        s_axis_data_tvalid = 1'b0;
        i_enable           = 1'b0;
        s_axis_data_tlast  = 1'b0;
        #1 i_reset_n = 1'b0;
        #1;
        check("rst_tdata",     m_axis_tdata,  0);
        check("rst_tvalid",    m_axis_tvalid, 0);
        check("rst_tlast",     m_axis_tlast,  0);
        check("rst_block_cnt", o_block_cnt,   0);
        check("rst_tlast_err", o_tlast_err,   0);
        check("rst_sat",       o_sat,         0);
        sb.delete();
        m_cnt = 0; m_np = 16; m_err = 1'b0; m_sat = 1'b0; m_blocks = 0; pend = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1 i_reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        idle(6);
        check("drain_empty", sb.size(), 0);
    endtask

    // Output monitor: every beat must match the next expected sample, on time.
    always @(negedge clock) begin
        if (i_reset_n === 1'b1 && m_axis_tvalid !== 1'b0) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL stale_beat: actual tdata=%0h required no beat", m_axis_tdata);
            end else begin
                mon_e = sb.pop_front();
                check("out_data",    m_axis_tdata, mon_e.data);
                check("out_tlast",   m_axis_tlast, mon_e.last);
                check("out_latency", cyc,          mon_e.edge_n);
                if (mon_e.last) m_blocks++;
            end
        end
    end

    initial begin
        vec_t       vt[5];
        int         i;
        logic [2:0] sel;

        i_reset_n          = 1'b1;
        i_enable           = 1'b0;
        i_NFFT_sel         = 3'd0;
        s_axis_data_tdata  = '0;
        s_axis_data_tvalid = 1'b0;
        s_axis_data_tlast  = 1'b0;
        i_exp_sample_real  = '0;
        i_exp_sample_imag  = '0;
        pend               = 1'b0;
        @(posedge clock);
        #1;
        do_reset();

        // Identity, rounding, rotation, saturation
        vt[0] = '{16'(1000),   16'(-500),   10'(256),  10'(0),    18'(1000), 18'(-500),   1'b0};
        vt[1] = '{16'(1),      16'(0),      10'(128),  10'(0),    18'(1),    18'(0),      1'b0};
        vt[2] = '{16'(-1),     16'(0),      10'(128),  10'(0),    18'(0),    18'(0),      1'b0};
        vt[3] = '{16'(1000),   16'(-500),   10'(0),    10'(-256), 18'(-500), 18'(-1000),  1'b0};
        vt[4] = '{16'(-32768), 16'(-32768), 10'(-512), 10'(-512), 18'(0),    18'(131071), 1'b1};
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b1, vt[k].a, vt[k].b, vt[k].c, vt[k].d, 1'b0, 3'd0);
            idle(3);
            check("vec_tvalid", m_axis_tvalid,       1);
            check("vec_re",     m_axis_tdata[17:0],  vt[k].re);
            check("vec_im",     m_axis_tdata[35:18], vt[k].im);
            check("vec_sat",    o_sat,               vt[k].sat);
        end
        idle(4);
        check("sat_sticky", o_sat, 1);
        drain();

        // Back-to-back framing, NP=16, tlast on 15 and 31
        do_reset();
        for (int k = 0; k < 32; k++) rnd_sample(k == 15 || k == 31, 3'd0);
        drain();
        check("frame_blocks", o_block_cnt, 2);
        check("frame_err",    o_tlast_err, 0);

        // Same framing with enable and valid gaps
        do_reset();
        i = 0;
        for (int k = 0; k < 300 && i < 32; k++) begin
            case ($urandom_range(0, 3))
                0: drive(1'b1, 1'b0, 16'($urandom), 16'($urandom), 10'($urandom), 10'($urandom),
                         1'($urandom), 3'($urandom));
                1: drive(1'b0, 1'b1, 16'($urandom), 16'($urandom), 10'($urandom), 10'($urandom),
                         1'($urandom), 3'($urandom));
                default: begin
                    rnd_sample(i == 15 || i == 31, 3'd0);
                    i++;
                end
            endcase
        end
        drain();
        check("gap_samples", i, 32);
        check("gap_blocks",  o_block_cnt, 2);
        check("gap_err",     o_tlast_err, 0);

        // Early input tlast on sample 10 resyncs; next output tlast on sample 26
        do_reset();
        for (int k = 0; k < 27; k++) rnd_sample(k == 10, 3'd0);
        drain();
        check("mis_err",    o_tlast_err, 1);
        check("mis_blocks", o_block_cnt, 1);

        // Reset mid-block with three samples in flight
        do_reset();
        for (int k = 0; k < 7; k++) rnd_sample(1'b0, 3'd0);
        do_reset();
        for (int k = 0; k < 16; k++) rnd_sample(k == 15, 3'd0);
        drain();
        check("rst_blk_blocks", o_block_cnt, 1);
        check("rst_blk_err",    o_tlast_err, 0);

        // Randomized traffic with select changes and sporadic tlast
        do_reset();
        sel = 3'd0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) sel = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd1;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  16'($urandom), 16'($urandom), 10'($urandom), 10'($urandom),
                  $urandom_range(0, 24) == 0, sel);
        end
        drain();
        check("rnd_err",    o_tlast_err, m_err);
        check("rnd_sat",    o_sat,       m_sat);
        check("rnd_blocks", o_block_cnt, m_blocks);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
